pll_lock_sequencer: RTL and testbench

Brings up one PLL and its global clock output, then supervises it. It pulses PLL enable and reset, waits for lock with a timeout and bounded retries, and qualifies lock stability. Only then does it enable the user global clock and release the active-low design reset. It runs on the free-running reference clock (the CLKIN output, never the PLL output) and sits between the PLL, GLBOUT and the user reset tree.

---
 rtl/pll_seq_pkg.sv | 35 +++
 rtl/sync_2ff.sv | 36 +++
 rtl/pll_lock_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pll_seq_pkg
//  Description : Shared types and helpers for the PLL lock sequencer:
//                the sequencer state encoding, the retry counter width and
//                the cycle-counter width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package pll_seq_pkg;

    // Sequencer states; the numeric values are exported on STATE for debug.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RESET     = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_STABILIZE = 3'd3,
        ST_RELEASE   = 3'd4,
        ST_RUN       = 3'd5
    } pll_state_e;

    localparam int c_retry_cnt_w = 4;

    // Width of a counter that must reach (largest cycle parameter - 1).
    // Never narrower than one bit.
    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : Generic two-flop synchronizer, reset value 0.
//  Ports       : clk  - destination clock
//                rst  - synchronous active-high reset
//                i_d  - asynchronous input bus
//                o_q  - synchronized output (two-cycle latency)
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/pll_lock_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pll_lock_sequencer
//  Description : Brings up a PLL (enable/reset pulse, lock wait with timeout
//                and bounded retries, lock-stability qualification), then
//                enables the user global clock and releases the user reset.
//                Supervises lock while running and relocks automatically.
//                Runs on the free-running reference clock.
//  Ports       : CLK, RST          - reference clock, sync active-high reset
//                START             - level request, low aborts to IDLE
//                PLL_LOCKED        - raw asynchronous PLL lock
//                PLL_EN            - PLL enable
//                LOCKED_STDY_RST   - one-cycle steady-lock clear pulse
//                GLB_EN, USR_RSTN  - global clock enable, active-low reset
//                READY             - high in RUN only
//                FAIL, LOCK_LOST   - sticky status flags
//                RETRY_CNT, STATE  - retries consumed, debug state
//  Revision    : 1.0 - initial release
// ============================================================================
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_HOLD_CYCLES  = 16,
    parameter int LOCK_WAIT_CYCLES = 4096,
    parameter int STABLE_CYCLES    = 256,
    parameter int RELEASE_CYCLES   = 2,
    parameter int MAX_RETRIES      = 3
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     START,
    input  logic                     PLL_LOCKED,
    output logic                     PLL_EN,
    output logic                     LOCKED_STDY_RST,
    output logic                     GLB_EN,
    output logic                     USR_RSTN,
    output logic                     READY,
    output logic                     FAIL,
    output logic                     LOCK_LOST,
    output logic [c_retry_cnt_w-1:0] RETRY_CNT,
    output logic [2:0]               STATE
);

    localparam int c_cnt_w = cnt_width(RST_HOLD_CYCLES, LOCK_WAIT_CYCLES,
                                       STABLE_CYCLES, RELEASE_CYCLES);

    logic                     w_lock_s;

    pll_state_e               r_state;
    logic [c_cnt_w-1:0]       r_cnt;
    logic [c_retry_cnt_w-1:0] r_retry;
    logic                     r_fail;
    logic                     r_lock_lost;
    logic                     r_pll_en;
    logic                     r_stdy_rst;
    logic                     r_glb_en;
    logic                     r_usr_rstn;
    logic                     r_ready;

    pll_state_e               w_state_nxt;
    logic [c_cnt_w-1:0]       w_cnt_nxt;
    logic [c_retry_cnt_w-1:0] w_retry_nxt;
    logic                     w_fail_nxt;
    logic                     w_lock_lost_nxt;
    logic                     w_stdy_rst_nxt;
    logic                     w_lock_fault;

    sync_2ff #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk (CLK),
        .rst (RST),
        .i_d (PLL_LOCKED),
        .o_q (w_lock_s)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt + 1'b1;
        w_retry_nxt     = r_retry;
        w_fail_nxt      = r_fail;
        w_lock_lost_nxt = r_lock_lost;
        w_stdy_rst_nxt  = 1'b0;
        w_lock_fault    = 1'b0;

        if (!START) begin
            // Dropping START also clears FAIL, which re-arms a restart.
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_retry_nxt = '0;
            w_fail_nxt  = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_cnt_nxt = '0;
                    if (!r_fail) w_state_nxt = ST_RESET;
                end
                ST_RESET: begin
                    if (r_cnt == c_cnt_w'(RST_HOLD_CYCLES - 1)) begin
                        w_state_nxt = ST_WAIT_LOCK;
                        w_cnt_nxt   = '0;
                    end
                end
                ST_WAIT_LOCK: begin
                    // Lock is tested first so that lock on the last count wins.
                    if (w_lock_s) begin
                        w_state_nxt    = ST_STABILIZE;
                        w_cnt_nxt      = '0;
                        w_stdy_rst_nxt = 1'b1;
                    end else if (r_cnt == c_cnt_w'(LOCK_WAIT_CYCLES - 1)) begin
                        w_lock_fault = 1'b1;
                    end
                end
                ST_STABILIZE: begin
                    if (!w_lock_s) begin
                        w_lock_fault = 1'b1;
                    end else if (r_cnt == c_cnt_w'(STABLE_CYCLES - 1)) begin
                        w_state_nxt = ST_RELEASE;
                        w_cnt_nxt   = '0;
                    end
                end
                ST_RELEASE: begin
                    if (r_cnt == c_cnt_w'(RELEASE_CYCLES - 1)) begin
                        w_state_nxt = ST_RUN;
                        w_cnt_nxt   = '0;
                    end
                end
                ST_RUN: begin
                    w_cnt_nxt = '0;
                    if (!w_lock_s) begin
                        w_state_nxt     = ST_RESET;
                        w_lock_lost_nxt = 1'b1;
                        w_retry_nxt     = '0;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase

            // Timeout and lock drop during qualification share one policy.
            if (w_lock_fault) begin
                w_cnt_nxt = '0;
                if (r_retry < c_retry_cnt_w'(MAX_RETRIES)) begin
                    w_state_nxt = ST_RESET;
                    w_retry_nxt = (r_retry == '1) ? r_retry : r_retry + 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_fail_nxt  = 1'b1;
                end
            end
        end
    end

    // Outputs are decoded from the next state so they change on the same
    // edge as the state register, with no input-to-output path.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_retry     <= '0;
            r_fail      <= 1'b0;
            r_lock_lost <= 1'b0;
            r_pll_en    <= 1'b0;
            r_stdy_rst  <= 1'b0;
            r_glb_en    <= 1'b0;
            r_usr_rstn  <= 1'b0;
            r_ready     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_retry     <= w_retry_nxt;
            r_fail      <= w_fail_nxt;
            r_lock_lost <= w_lock_lost_nxt;
            r_stdy_rst  <= w_stdy_rst_nxt;
            r_pll_en    <= (w_state_nxt == ST_WAIT_LOCK) || (w_state_nxt == ST_STABILIZE) ||
                           (w_state_nxt == ST_RELEASE)   || (w_state_nxt == ST_RUN);
            r_glb_en    <= (w_state_nxt == ST_RELEASE) || (w_state_nxt == ST_RUN);
            r_usr_rstn  <= (w_state_nxt == ST_RUN);
            r_ready     <= (w_state_nxt == ST_RUN);
        end
    end

    assign PLL_EN          = r_pll_en;
    assign LOCKED_STDY_RST = r_stdy_rst;
    assign GLB_EN          = r_glb_en;
    assign USR_RSTN        = r_usr_rstn;
    assign READY           = r_ready;
    assign FAIL            = r_fail;
    assign LOCK_LOST       = r_lock_lost;
    assign RETRY_CNT       = r_retry;
    assign STATE           = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pll_lock_sequencer
//  Description : Self-checking bench for pll_lock_sequencer. Expected values
//                are queued when stimulus is applied and popped against the
//                DUT outputs when they are observed.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_lock_sequencer;
    import pll_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       pll_locked;
    logic       pll_en;
    logic       stdy_rst;
    logic       glb_en;
    logic       usr_rstn;
    logic       ready;
    logic       fail;
    logic       lock_lost;
    logic [3:0] retry_cnt;
    logic [2:0] state;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string tag;
        int    exp;
    } sb_item_t;

    sb_item_t sb_q[$];

    pll_lock_sequencer #(
        .RST_HOLD_CYCLES  (4),
        .LOCK_WAIT_CYCLES (20),
        .STABLE_CYCLES    (8),
        .RELEASE_CYCLES   (2),
        .MAX_RETRIES      (2)
    ) u_dut (
        .CLK             (clk),
        .RST             (rst),
        .START           (start),
        .PLL_LOCKED      (pll_locked),
        .PLL_EN          (pll_en),
        .LOCKED_STDY_RST (stdy_rst),
        .GLB_EN          (glb_en),
        .USR_RSTN        (usr_rstn),
        .READY           (ready),
        .FAIL            (fail),
        .LOCK_LOST       (lock_lost),
        .RETRY_CNT       (retry_cnt),
        .STATE           (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic sb_push(input string tag, input int exp);
        sb_item_t item;
        item.tag = tag;
        item.exp = exp;
        sb_q.push_back(item);
    endtask

    task automatic sb_check(input int act);
        sb_item_t item;
        if (sb_q.size() == 0) begin
            chk("sb_underflow", 0, 1);
        end else begin
            item = sb_q.pop_front();
            chk(item.tag, act, item.exp);
        end
    endtask

    // Queue the full expected output vector (order matches observe_all).
    task automatic expect_all(input string tag, input int st, input int pe, input int sr,
                              input int ge, input int rn, input int rd, input int fl,
                              input int ll, input int rc);
        sb_push({tag, ".STATE"}, st);
        sb_push({tag, ".PLL_EN"}, pe);
        sb_push({tag, ".STDY_RST"}, sr);
        sb_push({tag, ".GLB_EN"}, ge);
        sb_push({tag, ".USR_RSTN"}, rn);
        sb_push({tag, ".READY"}, rd);
        sb_push({tag, ".FAIL"}, fl);
        sb_push({tag, ".LOCK_LOST"}, ll);
        sb_push({tag, ".RETRY_CNT"}, rc);
    endtask

    task automatic observe_all();
        sb_check(state);
        sb_check(pll_en);
        sb_check(stdy_rst);
        sb_check(glb_en);
        sb_check(usr_rstn);
        sb_check(ready);
        sb_check(fail);
        sb_check(lock_lost);
        sb_check(retry_cnt);
    endtask

    // Advance n rising edges, then step off the edge to sample/drive.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input string tag, input int st, input int budget);
        int c;
        c = 0;
        while (int'(state) != st && c < budget) begin
            tick(1);
            c++;
        end
        chk(tag, state, st);
    endtask

    task automatic count_in(input int st, input int budget, output int n);
        n = 0;
        while (int'(state) == st && n < budget) begin
            n++;
            tick(1);
        end
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        start      = 1'b0;
        pll_locked = 1'b0;
        tick(3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int c;
        int pulses;

        // ---------------- Scenario 1: reset values and normal bring-up
        do_reset();
        expect_all("rst", ST_IDLE, 0, 0, 0, 0, 0, 0, 0, 0);
        observe_all();
        rst   = 1'b0;
        start = 1'b1;
        sb_push("s1_pll_en_low_cycles", 4);
        sb_push("s1_state_after_reset", ST_WAIT_LOCK);
        sb_push("s1_stdy_pulses", 1);
        sb_push("s1_stab_to_glb_en", 8);
        sb_push("s1_glb_en_to_usr_rstn", 2);
        expect_all("s1_run", ST_RUN, 1, 0, 1, 1, 1, 0, 0, 0);
        wait_state("s1_enter_reset", ST_RESET, 5);
        n = 0;
        while (!pll_en && n < 50) begin
            n++;
            tick(1);
        end
        sb_check(n);
        sb_check(state);
        tick(5);
        pll_locked = 1'b1;
        wait_state("s1_enter_stab", ST_STABILIZE, 30);
        pulses = int'(stdy_rst);
        c = 0;
        while (!glb_en && c < 50) begin
            tick(1);
            c++;
            pulses += int'(stdy_rst);
        end
        sb_check(pulses);
        sb_check(c);
        c = 0;
        while (!usr_rstn && c < 50) begin
            tick(1);
            c++;
        end
        sb_check(c);
        observe_all();

        // ---------------- Scenario 2: never locks, retries then FAIL
        do_reset();
        rst   = 1'b0;
        start = 1'b1;
        for (int w = 0; w < 3; w++) begin
            wait_state($sformatf("s2_enter_wait%0d", w), ST_WAIT_LOCK, 30);
            sb_push($sformatf("s2_window%0d_len", w), 20);
            if (w < 2) begin
                sb_push($sformatf("s2_state_after%0d", w), ST_RESET);
                sb_push($sformatf("s2_retry_after%0d", w), w + 1);
            end else begin
                sb_push("s2_state_fail", ST_IDLE);
                sb_push("s2_retry_fail", 2);
            end
            count_in(ST_WAIT_LOCK, 100, n);
            sb_check(n);
            sb_check(state);
            sb_check(retry_cnt);
        end
        chk("s2_fail_set", fail, 1);
        tick(3);
        chk("s2_fail_blocks_restart", state, ST_IDLE);
        start = 1'b0;
        tick(1);
        chk("s2_fail_cleared", fail, 0);
        chk("s2_retry_cleared", retry_cnt, 0);
        start = 1'b1;
        tick(1);
        chk("s2_restart", state, ST_RESET);

        // ---------------- Scenario 3: lock glitch during qualification
        do_reset();
        rst   = 1'b0;
        start = 1'b1;
        wait_state("s3_enter_wait", ST_WAIT_LOCK, 10);
        pll_locked = 1'b1;
        tick(5);
        chk("s3_in_stab", state, ST_STABILIZE);
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        wait_state("s3_retry_reset", ST_RESET, 10);
        chk("s3_retry_cnt", retry_cnt, 1);
        wait_state("s3_reach_run", ST_RUN, 100);
        expect_all("s3_run", ST_RUN, 1, 0, 1, 1, 1, 0, 0, 1);
        observe_all();

        // ---------------- Scenario 4: lock loss in RUN and relock
        pll_locked = 1'b0;
        sb_push("s4_ready_d1", 1);
        sb_push("s4_ready_d2", 1);
        expect_all("s4_drop", ST_RESET, 0, 0, 0, 0, 0, 0, 1, 0);
        tick(1);
        sb_check(ready);
        tick(1);
        sb_check(ready);
        tick(1);
        observe_all();
        pll_locked = 1'b1;
        wait_state("s4_relock_run", ST_RUN, 100);
        chk("s4_lost_sticky", lock_lost, 1);
        chk("s4_retry_zero", retry_cnt, 0);
        start = 1'b0;
        tick(1);
        expect_all("s4_abort_run", ST_IDLE, 0, 0, 0, 0, 0, 0, 1, 0);
        observe_all();
        start = 1'b1;
        wait_state("s4_back_run", ST_RUN, 100);

        // ---------------- Scenario 5: RST in RUN, START abort mid-STABILIZE
        rst = 1'b1;
        tick(1);
        expect_all("s5_rst_run", ST_IDLE, 0, 0, 0, 0, 0, 0, 0, 0);
        observe_all();
        rst = 1'b0;
        wait_state("s5_enter_stab", ST_STABILIZE, 40);
        tick(2);
        chk("s5_still_stab", state, ST_STABILIZE);
        start = 1'b0;
        tick(1);
        expect_all("s5_abort", ST_IDLE, 0, 0, 0, 0, 0, 0, 0, 0);
        observe_all();

        // ---------------- Scenario 6: lock on the final WAIT_LOCK count
        do_reset();
        rst   = 1'b0;
        start = 1'b1;
        wait_state("s6_enter_wait", ST_WAIT_LOCK, 10);
        tick(17);
        pll_locked = 1'b1;
        tick(2);
        chk("s6_wait_at_19", state, ST_WAIT_LOCK);
        tick(1);
        chk("s6_stab_entered", state, ST_STABILIZE);
        chk("s6_stdy_pulse", stdy_rst, 1);
        chk("s6_no_retry", retry_cnt, 0);

        chk("sb_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
